// File: rtl/mips_instr_encoder.sv
// Builds 32-bit MIPS R/I/J instruction words from a symbolic op and fields,
// then writes them into instruction memory at consecutive word addresses.
module mips_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 op_sel,
    input  logic [4:0]                 rs,
    input  logic [4:0]                 rt,
    input  logic [4:0]                 rd,
    input  logic [15:0]                imm,
    input  logic [25:0]                target,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       err
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic               w_full;
    logic               w_transfer;
    logic               w_illegal;
    logic [31:0]        w_word;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign in_ready   = (r_state == S_IDLE) & ~w_full & ~clr;
    assign w_transfer = in_valid & in_ready;
    assign w_illegal  = (op_sel > 4'd12);

    // Opcode/funct values match what the single-cycle controller decodes.
    always_comb begin
        w_word = 32'h0;
        case (op_sel)
            4'd0:  w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:  w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:  w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:  w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:  w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5:  w_word = {6'b000010, target};
            4'd6:  w_word = {6'b000011, target};
            4'd7:  w_word = {6'b000100, rs, rt, imm};
            4'd8:  w_word = {6'b000101, rs, rt, imm};
            4'd9:  w_word = {6'b001000, rs, rt, imm};
            4'd10: w_word = {6'b001100, rs, rt, imm};
            4'd11: w_word = {6'b100011, rs, rt, imm};
            4'd12: w_word = {6'b101011, rs, rt, imm};
            default: w_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mem_we <= 1'b0;
            r_addr   <= ADDR_W'(BASE_ADDR);
            r_wdata  <= 32'h0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else if (clr) begin
            // A pending write is dropped and never counted.
            r_state  <= S_IDLE;
            r_mem_we <= 1'b0;
            r_addr   <= ADDR_W'(BASE_ADDR);
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_transfer) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wdata  <= w_word;
                            r_mem_we <= 1'b1;
                            r_state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_mem_we <= 1'b0;
                        r_state  <= S_IDLE;
                        r_count  <= r_count + CNT_W'(1);
                        r_addr   <= r_addr + ADDR_W'(4);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign err       = r_err;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized self-checking bench for mips_instr_encoder against a table-driven
// model of the MIPS encoding and the sequential write/count behaviour.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int mCount;
    int mAddr;
    logic [31:0] lastWord;

    int rFunct[5] = '{32, 34, 36, 37, 42};
    int jOp[2]    = '{2, 3};
    int iOp[6]    = '{4, 5, 8, 12, 35, 43};

    always #5 clk = ~clk;

    mips_instr_encoder #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op_sel(op_sel),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .imm(imm),
        .target(target),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .count(count),
        .full(full),
        .err(err)
    );

    // Field positions computed arithmetically: opcode*2^26 + rs*2^21 + rt*2^16 + ...
    function automatic logic [31:0] refWord(input int op, input int frs, input int frt,
                                            input int frd, input int fimm, input int ftgt);
        longint w;
        if (op <= 4)
            w = longint'(frs) * 2097152 + longint'(frt) * 65536 + longint'(frd) * 2048 + rFunct[op];
        else if (op <= 6)
            w = longint'(jOp[op-5]) * 67108864 + ftgt;
        else if (op <= 12)
            w = longint'(iOp[op-7]) * 67108864 + longint'(frs) * 2097152 + longint'(frt) * 65536 + fimm;
        else
            w = 0;
        return w[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int op, input int frs, input int frt, input int frd,
                                 input int fimm, input int ftgt);
        op_sel   = 4'(op);
        rs       = 5'(frs);
        rt       = 5'(frt);
        rd       = 5'(frd);
        imm      = 16'(fimm);
        target   = 26'(ftgt);
        in_valid = 1'b1;
    endtask

    // One full accepted transaction from IDLE, with ackDelay stall cycles before mem_ack.
    task automatic doWrite(input int op, input int frs, input int frt, input int frd,
                           input int fimm, input int ftgt, input int ackDelay);
        logic [31:0] exp;
        exp = refWord(op, frs, frt, frd, fimm, ftgt);
        applyStimulus(op, frs, frt, frd, fimm, ftgt);
        #1;
        checkOutput("in_ready_idle", 32'(in_ready), 32'(mCount != DEPTH));
        tick();
        in_valid = 1'b0;
        if (op > 12) begin
            checkOutput("err_pulse", 32'(err), 32'd1);
            checkOutput("no_we_illegal", 32'(mem_we), 32'd0);
            tick();
            checkOutput("err_clear", 32'(err), 32'd0);
            checkOutput("count_illegal", 32'(count), 32'(mCount));
            checkOutput("addr_illegal", 32'(mem_addr), 32'(mAddr));
        end else begin
            checkOutput("we_rise", 32'(mem_we), 32'd1);
            checkOutput("wr_addr", 32'(mem_addr), 32'(mAddr));
            checkOutput("wr_data", mem_wdata, exp);
            lastWord = mem_wdata;
            for (int i = 0; i < ackDelay; i++) begin
                tick();
                checkOutput("we_hold", 32'(mem_we), 32'd1);
                checkOutput("data_hold", mem_wdata, exp);
                checkOutput("addr_hold", 32'(mem_addr), 32'(mAddr));
                checkOutput("ready_busy", 32'(in_ready), 32'd0);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            mCount++;
            mAddr = (mAddr + 4) % (1 << ADDR_W);
            checkOutput("we_fall", 32'(mem_we), 32'd0);
            checkOutput("count_inc", 32'(count), 32'(mCount));
            checkOutput("addr_inc", 32'(mem_addr), 32'(mAddr));
            checkOutput("full_flag", 32'(full), 32'(mCount == DEPTH));
        end
    endtask

    task automatic doClear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mCount = 0;
        mAddr  = BASE;
        checkOutput("clr_count", 32'(count), 32'd0);
        checkOutput("clr_addr", 32'(mem_addr), 32'(BASE));
        checkOutput("clr_we", 32'(mem_we), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
        mCount = 0; mAddr = BASE; lastWord = '0;
        #12;
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'(BASE));
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        doWrite(0, 1, 2, 3, 0, 0, 1);
        checkOutput("add_literal", lastWord, 32'h00221820);
        checkOutput("add_next_addr", 32'(mem_addr), 32'h004);

        doClear();
        doWrite(11, 9, 8, 0, 16'h0004, 0, 0);
        checkOutput("lw_literal", lastWord, 32'h8D280004);
        doWrite(5, 0, 0, 0, 0, 26'h10, 0);
        checkOutput("j_literal", lastWord, 32'h08000010);
        doWrite(7, 1, 2, 0, 16'hFFFF, 0, 5);
        checkOutput("beq_literal", lastWord, 32'h1022FFFF);
        doWrite(13, 3, 4, 5, 16'h1234, 0, 0);
        doWrite(3, 4, 5, 6, 0, 0, 2);

        // Full: the fifth request must be held off.
        applyStimulus(1, 7, 7, 7, 0, 0);
        #1;
        checkOutput("ready_full", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("no_we_full", 32'(mem_we), 32'd0);
        checkOutput("count_full", 32'(count), 32'(DEPTH));
        checkOutput("full_held", 32'(full), 32'd1);

        // clr together with in_valid in IDLE blocks the transfer.
        doClear();
        clr = 1'b1;
        applyStimulus(2, 1, 1, 1, 0, 0);
        #1;
        checkOutput("ready_clr", 32'(in_ready), 32'd0);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        checkOutput("no_we_clr", 32'(mem_we), 32'd0);
        checkOutput("count_clr_idle", 32'(count), 32'd0);

        // clr during WRITE beats a simultaneous mem_ack.
        applyStimulus(9, 2, 3, 0, 16'h00FF, 0);
        tick();
        in_valid = 1'b0;
        checkOutput("we_before_clr", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        doClear();
        mem_ack = 1'b0;

        // Async reset during WRITE.
        applyStimulus(12, 4, 5, 0, 16'h0010, 0);
        tick();
        in_valid = 1'b0;
        checkOutput("we_before_rst", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mid_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mid_addr", 32'(mem_addr), 32'(BASE));
        tick();
        checkOutput("rst_hold_we", 32'(mem_we), 32'd0);
        checkOutput("rst_hold_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mCount = 0;
        mAddr  = BASE;
        tick();

        for (int n = 0; n < 300; n++) begin
            if (mCount == DEPTH || $urandom_range(0, 9) == 0) begin
                doClear();
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    mem_ack = 1'b1;
                    tick();
                    mem_ack = 1'b0;
                    checkOutput("ack_idle_ignored", 32'(count), 32'(mCount));
                end
                doWrite(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 65535)), int'($urandom & 32'h03FF_FFFF),
                        int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
